// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard link (host transmitter and receiver).
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, DONE
   } ps2_state_t;

   localparam int PS2_FRAME_BITS = 11;

   localparam logic [7:0] CMD_RESET   = 8'hFF;
   localparam logic [7:0] CMD_SET_LED = 8'hED;
   localparam logic [7:0] CMD_ENABLE  = 8'hF4;
   localparam logic [7:0] ACK_BYTE    = 8'hFA;

   // Bits shifted out after the start bit: {stop, odd parity, data}, sent LSB first.
   function automatic logic [9:0] ps2_shift_frame(input logic [7:0] d);
      return {1'b1, ~^d, d};
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side handshake of the PS/2 host transmitter.
interface ps2_host_tx_if;
   logic       start;
   logic [7:0] tx_data;
   logic       busy;
   logic       done;
   logic       ack_ok;
   logic       error;

   modport master (output start, tx_data, input busy, done, ack_ok, error);
   modport slave  (input start, tx_data, output busy, done, ack_ok, error);
endinterface

// File: rtl/ps2_line_sync.sv
// Synchronises raw ps2 clock/data lines and strobes one cycle on each clock fall.
module ps2_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic clk_raw,
   input  logic data_raw,
   output logic clk_s,
   output logic data_s,
   output logic clk_fall
);

   logic [SYNC_STAGES-1:0] clk_sh;
   logic [SYNC_STAGES-1:0] data_sh;
   logic                   clk_q;

   // Reset to the idle-high bus level so no false fall follows reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clk_sh  <= '1;
         data_sh <= '1;
         clk_q   <= 1'b1;
      end else begin
         clk_sh[0]  <= clk_raw;
         data_sh[0] <= data_raw;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            clk_sh[i]  <= clk_sh[i-1];
            data_sh[i] <= data_sh[i-1];
         end
         clk_q <= clk_sh[SYNC_STAGES-1];
      end
   end

   assign clk_s    = clk_sh[SYNC_STAGES-1];
   assign data_s   = data_sh[SYNC_STAGES-1];
   assign clk_fall = clk_q & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 10 device-clocked bits, ACK check.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic          clock,
   input  logic          reset,
   ps2_host_tx_if.slave  cmd,
   input  logic          ps2_clk_in,
   input  logic          ps2_data_in,
   output logic          ps2_clk_oe,
   output logic          ps2_data_oe
);

   localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int BW = $clog2(PS2_FRAME_BITS);

   ps2_state_t    state, state_n;
   logic [9:0]    frame, frame_n;
   logic [BW-1:0] bit_cnt, bit_cnt_n;
   logic [IW-1:0] inh_cnt, inh_n;
   logic [TW-1:0] to_cnt, to_n;
   logic          data_oe_r, doe_n;
   logic          ack_r, ack_n;
   logic          err_r, err_n;

   logic clk_s, data_s, clk_fall;

   ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clock    (clock),
      .reset    (reset),
      .clk_raw  (ps2_clk_in),
      .data_raw (ps2_data_in),
      .clk_s    (clk_s),
      .data_s   (data_s),
      .clk_fall (clk_fall)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         frame     <= '0;
         bit_cnt   <= '0;
         inh_cnt   <= '0;
         to_cnt    <= '0;
         data_oe_r <= 1'b0;
         ack_r     <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         state     <= state_n;
         frame     <= frame_n;
         bit_cnt   <= bit_cnt_n;
         inh_cnt   <= inh_n;
         to_cnt    <= to_n;
         data_oe_r <= doe_n;
         ack_r     <= ack_n;
         err_r     <= err_n;
      end
   end

   always_comb begin
      state_n   = state;
      frame_n   = frame;
      bit_cnt_n = bit_cnt;
      inh_n     = inh_cnt;
      to_n      = to_cnt;
      doe_n     = data_oe_r;
      ack_n     = ack_r;
      err_n     = err_r;
      case (state)
         IDLE: if (cmd.start) begin
            frame_n   = ps2_shift_frame(cmd.tx_data);
            ack_n     = 1'b0;
            err_n     = 1'b0;
            inh_n     = '0;
            bit_cnt_n = '0;
            state_n   = INHIBIT;
         end
         INHIBIT: begin
            if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
               doe_n   = 1'b1;
               state_n = RTS;
            end else begin
               inh_n = inh_cnt + 1'b1;
            end
         end
         RTS: begin
            to_n      = '0;
            bit_cnt_n = '0;
            state_n   = SEND;
         end
         // Host changes data while the device holds clock low; the device samples on the rise.
         SEND: if (clk_fall) begin
            doe_n     = ~frame[bit_cnt];
            bit_cnt_n = bit_cnt + 1'b1;
            if (bit_cnt == BW'(PS2_FRAME_BITS - 2)) state_n = ACK;
         end
         ACK: if (clk_fall) begin
            ack_n   = ~data_s;
            state_n = WAIT_IDLE;
         end
         WAIT_IDLE: if (clk_s && data_s) begin
            err_n   = ~ack_r;
            state_n = DONE;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase

      // A silent or stuck device must not hold the link forever.
      if (state inside {SEND, ACK, WAIT_IDLE}) begin
         to_n = to_cnt + 1'b1;
         if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            doe_n   = 1'b0;
            ack_n   = 1'b0;
            err_n   = 1'b1;
            state_n = DONE;
         end
      end
   end

   assign ps2_clk_oe  = state inside {INHIBIT, RTS};
   assign ps2_data_oe = data_oe_r;
   assign cmd.busy    = state inside {INHIBIT, RTS, SEND, ACK, WAIT_IDLE};
   assign cmd.done    = (state == DONE);
   assign cmd.ack_ok  = ack_r;
   assign cmd.error   = err_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2 keyboard on the open-collector lines.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH  = 20;
   localparam int TOUT = 600;
   localparam int HALF = 10;

   localparam int M_ACK   = 0;
   localparam int M_NACK  = 1;
   localparam int M_NOCLK = 2;
   localparam int M_ABORT = 3;

   typedef struct packed {
      logic       ack;
      logic       err;
      logic       chkb;
      logic [9:0] bits;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic clk_oe, data_oe;
   logic dev_clk_low = 1'b0;
   logic dev_data_low = 1'b0;
   wire  clk_line  = ~(clk_oe | dev_clk_low);
   wire  data_line = ~(data_oe | dev_data_low);

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   logic [9:0] dev_bits;

   ps2_host_tx_if cif();

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TOUT), .SYNC_STAGES(2)) dut (
      .clock       (clock),
      .reset       (reset),
      .cmd         (cif),
      .ps2_clk_in  (clk_line),
      .ps2_data_in (data_line),
      .ps2_clk_oe  (clk_oe),
      .ps2_data_oe (data_oe)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every done pulse is matched against the oldest expected response.
   always @(negedge clock) begin
      if (!reset && cif.done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("ack_ok", 32'(cif.ack_ok), 32'(mon_e.ack));
            chk("error", 32'(cif.error), 32'(mon_e.err));
            chk("clk_oe_at_done", 32'(clk_oe), 0);
            chk("data_oe_at_done", 32'(data_oe), 0);
            if (mon_e.chkb) chk("line_bits", 32'(dev_bits), 32'(mon_e.bits));
         end
      end
   end

   task automatic issue(input logic [7:0] b);
      @(negedge clock);
      cif.start   = 1'b1;
      cif.tx_data = b;
      @(negedge clock);
      cif.start   = 1'b0;
      chk("busy_after_start", 32'(cif.busy), 1);
   endtask

   // Keyboard side: detect request-to-send, clock out 11 periods, sample on rises, ACK on fall 11.
   task automatic dev_xfer(input int mode);
      int n;
      dev_bits = '0;
      n = 0;
      while (!clk_oe && n < 200) begin @(negedge clock); n++; end
      if (!clk_oe) begin chk("inhibit_seen", 0, 1); return; end
      n = 0;
      while (clk_oe && n < 1000) begin @(negedge clock); n++; end
      chk("inhibit_len", n, INH + 1);
      chk("start_bit", 32'(data_oe), 1);
      if (mode == M_NOCLK) return;
      for (int i = 1; i <= 11; i++) begin
         if (i == 11 && mode == M_ACK) dev_data_low = 1'b1;
         repeat (HALF) @(negedge clock);
         dev_clk_low = 1'b1;
         if (mode == M_ABORT && i == 5) begin
            repeat (4) @(negedge clock);
            return;
         end
         repeat (HALF) @(negedge clock);
         if (i <= 10) dev_bits[i-1] = data_line;
         dev_clk_low = 1'b0;
      end
      repeat (3) @(negedge clock);
      dev_data_low = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (cif.busy && n < 2000) begin @(negedge clock); n++; end
      if (cif.busy) chk("idle_timeout", 1, 0);
      repeat (3) @(negedge clock);
   endtask

   task automatic send(input logic [7:0] b, input int mode, input exp_t e);
      exp_q.push_back(e);
      issue(b);
      dev_xfer(mode);
      wait_idle();
   endtask

   initial begin
      int n;
      cif.start   = 1'b0;
      cif.tx_data = 8'h00;
      repeat (3) @(negedge clock);
      chk("rst_clk_oe", 32'(clk_oe), 0);
      chk("rst_data_oe", 32'(data_oe), 0);
      chk("rst_busy", 32'(cif.busy), 0);
      chk("rst_done", 32'(cif.done), 0);
      chk("rst_ack_ok", 32'(cif.ack_ok), 0);
      chk("rst_error", 32'(cif.error), 0);
      reset = 1'b0;
      repeat (3) @(negedge clock);

      send(CMD_ENABLE,  M_ACK,  '{ack: 1'b1, err: 1'b0, chkb: 1'b1, bits: 10'h2F4});
      send(CMD_SET_LED, M_ACK,  '{ack: 1'b1, err: 1'b0, chkb: 1'b1, bits: 10'h3ED});
      send(CMD_RESET,   M_ACK,  '{ack: 1'b1, err: 1'b0, chkb: 1'b1, bits: 10'h3FF});

      // Device never answers the request-to-send.
      exp_q.push_back('{ack: 1'b0, err: 1'b1, chkb: 1'b0, bits: 10'h000});
      issue(CMD_ENABLE);
      dev_xfer(M_NOCLK);
      n = 0;
      while (!cif.done && n < 2 * TOUT) begin @(negedge clock); n++; end
      chk("timeout_cycles", n, TOUT);
      wait_idle();

      send(ACK_BYTE, M_NACK, '{ack: 1'b0, err: 1'b1, chkb: 1'b1, bits: 10'h3FA});
      repeat (5) @(negedge clock);
      chk("error_hold", 32'(cif.error), 1);
      chk("ack_ok_hold", 32'(cif.ack_ok), 0);

      // Reset while the device holds clock low at fall 5.
      issue(CMD_ENABLE);
      dev_xfer(M_ABORT);
      chk("bit4_on_line", 32'(data_oe), 0);
      chk("busy_mid_frame", 32'(cif.busy), 1);
      #2 reset = 1'b1;
      #1;
      chk("async_clk_oe", 32'(clk_oe), 0);
      chk("async_data_oe", 32'(data_oe), 0);
      chk("async_busy", 32'(cif.busy), 0);
      dev_clk_low = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      repeat (5) @(negedge clock);
      send(CMD_RESET, M_ACK, '{ack: 1'b1, err: 1'b0, chkb: 1'b1, bits: 10'h3FF});

      // A second start while busy with different data must not disturb the frame.
      exp_q.push_back('{ack: 1'b1, err: 1'b0, chkb: 1'b1, bits: 10'h2F4});
      issue(CMD_ENABLE);
      fork
         dev_xfer(M_ACK);
         begin
            repeat (5) @(negedge clock);
            cif.start   = 1'b1;
            cif.tx_data = 8'h00;
            @(negedge clock);
            cif.start   = 1'b0;
         end
      join
      wait_idle();

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
